occ_fetch_cache: RTL and testbench

- Sits between the accelerator's Occ request port and the backing Occ memory.
- Serves each request (ce/addr in; data/valid out) from a small direct-mapped cache, or fetches from backing memory over a req/ack handshake on a miss.
- Provides the data_Occ_i / data_Occ_valid_i stream the alignment FSM consumes.
- Exposes hit/miss counters for performance tuning.

---
 rtl/occ_pkg.sv | 22 ++
 rtl/occ_cache_array.sv | 51 +++++
 rtl/occ_fetch_cache.sv | 145 ++++++++++++++
 tb/tb_occ_fetch_cache.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/occ_pkg.sv
// Shared types and defaults for the Occ fetch cache.
// Cache geometry is derived from the Occ address width.
package occ_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_RESP   = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  function automatic int tag_w(input int addr_w, input int idx_w);
    return addr_w - idx_w;
  endfunction

endpackage

// File: rtl/occ_cache_array.sv
// Direct-mapped one-word-per-line storage.
// Combinational read, synchronous write, flushable valid bits.
module occ_cache_array
  import occ_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = tag_w(DEF_ADDR_W, DEF_IDX_W),
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic              rvalid_o,
  output logic [TAG_W-1:0]  rtag_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // A fill on the flush edge keeps its own line valid.
  always_comb begin
    valid_d = flush_i ? '0 : valid_q;
    if (we_i) valid_d[widx_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_mem[widx_i]  <= wtag_i;
      data_mem[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_mem[ridx_i];
  assign rdata_o  = data_mem[ridx_i];

endmodule

// File: rtl/occ_fetch_cache.sv
// Occ request front-end: direct-mapped cache with a
// req/ack miss path and saturating hit/miss counters.
module occ_fetch_cache
  import occ_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_W = tag_w(ADDR_W, IDX_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dvalid_q, dvalid_d;
  logic              mem_req_q, mem_req_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              fill_we;

  assign idx     = req_addr_q[IDX_W-1:0];
  assign tag     = req_addr_q[ADDR_W-1:IDX_W];
  assign hit     = line_valid && (line_tag == tag);
  assign fill_we = (state_q == S_FILL) && mem_ack_i;

  occ_cache_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .we_i     (fill_we),
    .widx_i   (idx),
    .wtag_i   (tag),
    .wdata_i  (mem_rdata_i),
    .ridx_i   (idx),
    .rvalid_o (line_valid),
    .rtag_o   (line_tag),
    .rdata_o  (line_data)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    dvalid_d   = 1'b0;
    mem_req_d  = mem_req_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ce_i) begin
          req_addr_d = addr_i;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          data_d   = line_data;
          dvalid_d = 1'b1;
          if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + 1'b1;
          state_d  = S_HOLD;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = req_addr_q;
          if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          data_d    = mem_rdata_i;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        dvalid_d = 1'b1;
        state_d  = S_HOLD;
      end
      // Wait for the accelerator to drop ce_i before serving again.
      S_HOLD: begin
        if (!ce_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      dvalid_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      dvalid_q   <= dvalid_d;
      mem_req_q  <= mem_req_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dvalid_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_occ_fetch_cache.sv
// Self-checking bench for occ_fetch_cache: directed table,
// reset-in-fill sequence and randomized requests vs a line model.
module tb_occ_fetch_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [7:0]  addr_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        mem_req_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        flush_i;
  logic [15:0] hit_cnt_o;
  logic [15:0] miss_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference: which address each line currently holds
  bit   mv [16];
  logic [7:0] ma [16];
  int   exp_h, exp_m;

  occ_fetch_cache dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .addr_i       (addr_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .flush_i      (flush_i),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (a == 8'h25) return 32'hDEADBEEF;
    return {a, a ^ 8'h5A, 8'hC3, ~a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    exp_h = 0;
    exp_m = 0;
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic run_req(input logic [7:0] a, input int dly,
                         input bit fl_ack, input int hold,
                         output bit was_miss);
    logic [7:0]  maddr;
    logic [31:0] d;
    int  lat, reqc, vcnt;
    bit  got, exp_hit;
    int  ix;
    ix      = int'(a[3:0]);
    exp_hit = mv[ix] && (ma[ix] == a);
    was_miss = 1'b0;
    got  = 1'b0;
    lat  = 0;
    reqc = 0;
    maddr = '0;
    d     = '0;
    addr_i = a;
    ce_i   = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_ack_i) begin
        mem_ack_i   = 1'b0;
        flush_i     = 1'b0;
        mem_rdata_i = '0;
      end else if (mem_req_o) begin
        if (!was_miss) begin
          was_miss = 1'b1;
          maddr    = mem_addr_o;
        end
        reqc++;
        if (reqc > dly) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          flush_i     = fl_ack;
        end
      end
      if (data_valid_o) begin
        got = 1'b1;
        d   = data_o;
      end
    end
    chk("resp_seen", {31'd0, got}, 32'd1);
    chk("hit", {31'd0, !was_miss}, {31'd0, exp_hit});
    if (was_miss) chk("mem_addr", {24'd0, maddr}, {24'd0, a});
    chk("data", d, mem_word(a));
    chk("latency", lat, exp_hit ? 2 : 4 + dly);
    if (exp_hit) begin
      if (exp_h < 16'hFFFF) exp_h++;
    end else begin
      if (exp_m < 16'hFFFF) exp_m++;
      if (fl_ack)
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
      mv[ix] = 1'b1;
      ma[ix] = a;
    end
    vcnt = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (data_valid_o || mem_req_o) vcnt++;
    end
    chk("hold_quiet", vcnt, 0);
    chk("hit_cnt", {16'd0, hit_cnt_o}, exp_h);
    chk("miss_cnt", {16'd0, miss_cnt_o}, exp_m);
    ce_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] addr;
    int         dly;
    bit         fl_before;
    bit         fl_ack;
    int         hold;
    bit         exp_hit;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit  m;
    int  cnt;
    logic [7:0] ra;

    tbl[0]  = '{8'h25, 3, 0, 0, 1, 0};
    tbl[1]  = '{8'h25, 0, 0, 0, 5, 1};
    tbl[2]  = '{8'h25, 0, 0, 0, 1, 1};
    tbl[3]  = '{8'h35, 1, 0, 0, 1, 0};
    tbl[4]  = '{8'h25, 0, 0, 0, 1, 0};
    tbl[5]  = '{8'h10, 0, 0, 0, 1, 0};
    tbl[6]  = '{8'h11, 2, 0, 0, 1, 0};
    tbl[7]  = '{8'h10, 0, 1, 0, 1, 0};
    tbl[8]  = '{8'h12, 1, 0, 1, 1, 0};
    tbl[9]  = '{8'h12, 0, 0, 0, 1, 1};
    tbl[10] = '{8'h10, 0, 0, 0, 1, 0};
    tbl[11] = '{8'h00, 0, 0, 0, 1, 0};
    tbl[12] = '{8'hFF, 2, 0, 0, 1, 0};
    tbl[13] = '{8'hFF, 0, 0, 0, 1, 1};

    rst = 1'b1;
    ce_i = 1'b0;
    addr_i = '0;
    mem_rdata_i = '0;
    mem_ack_i = 1'b0;
    flush_i = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {31'd0, data_valid_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_maddr", {24'd0, mem_addr_o}, 32'd0);
    chk("rst_cnts", {hit_cnt_o, miss_cnt_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].fl_before) flush_pulse();
      run_req(tbl[i].addr, tbl[i].dly, tbl[i].fl_ack,
              tbl[i].hold, m);
      chk($sformatf("tbl%0d_hit", i), {31'd0, !m},
          {31'd0, tbl[i].exp_hit});
    end

    // Reset while a fill is outstanding
    addr_i = 8'h40;
    ce_i = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("fill_req", {31'd0, mem_req_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_fill_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_fill_cnt", {hit_cnt_o, miss_cnt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ce_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    mem_ack_i = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (data_valid_o || mem_req_o) cnt++;
    end
    chk("late_ack_ignored", cnt, 0);
    model_reset();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) flush_pulse();
      ra = 8'($urandom_range(0, 47));
      if ($urandom_range(0, 9) == 0) ra = 8'($urandom_range(0, 255));
      run_req(ra, int'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0), int'($urandom_range(1, 3)), m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
